// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one shared partial-product slice, one digit per clock.
// Optional BOOTH_SEQ_ZERO_SKIP_EN ends CALC early once every remaining digit is zero.
module booth_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);

    localparam int CNT_W = $clog2(WIDTH/2) + 1;
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH/2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   recoder;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    mcandExt;
    logic [PW-1:0]    ppDigit;
    logic [PW-1:0]    ppShifted;
    logic [PW-1:0]    accSum;
    logic             lastDigit;
    logic             skip;

    assign mcandExt = {{WIDTH{mcand[WIDTH-1]}}, mcand};

    // Booth digit from the low three recoder bits, applied to the sign-extended multiplicand
    always_comb begin
        ppDigit = '0;
        case (recoder[2:0])
            3'b001, 3'b010: ppDigit = mcandExt;
            3'b011:         ppDigit = mcandExt << 1;
            3'b100:         ppDigit = -(mcandExt << 1);
            3'b101, 3'b110: ppDigit = -mcandExt;
            default:        ppDigit = '0;
        endcase
    end

    assign ppShifted = ppDigit << {cnt, 1'b0};
    assign accSum    = acc + ppShifted;
    assign lastDigit = (cnt == LAST);

`ifdef BOOTH_SEQ_ZERO_SKIP_EN
    // All-zero or all-one recoder bits mean every remaining digit decodes to zero
    assign skip = (recoder == '0) || (recoder == '1) || (mcand == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (in_valid)               nextState = CALC;
            CALC: if (skip || lastDigit)      nextState = DONE;
            DONE: if (out_ready)              nextState = IDLE;
            default:                          nextState = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == CALC) || (state == DONE);
    end

    // Operand capture, digit stepping and product hand-off; p only moves when CALC finishes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            recoder <= '0;
            acc     <= '0;
            cnt     <= '0;
            p       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand   <= a;
                        recoder <= {b, 1'b0};
                        acc     <= '0;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    if (skip) begin
                        p <= acc;
                    end else begin
                        acc     <= accSum;
                        recoder <= {{2{recoder[WIDTH]}}, recoder[WIDTH:2]};
                        cnt     <= cnt + 1'b1;
                        if (lastDigit) begin
                            p <= accSum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed self-checking bench for booth_seq_ctrl (WIDTH=8): vector table plus multi-cycle corner sequences.
module tb_booth_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        longint            expP;
    } vec_t;

    vec_t vecs[12];

    booth_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Present one operand pair in IDLE and let the accept edge pass
    task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Count edges after accept until out_valid; an expired budget is reported as a failure
    task automatic waitDone(input string name, output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) checkOutput({name, "_timeout"}, 0, 1);
    endtask

    int lat;

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        vecs[0]  = '{8'sd3,    8'sd5,    15};
        vecs[1]  = '{-8'sd128, -8'sd128, 16384};
        vecs[2]  = '{-8'sd128, 8'sd127,  -16256};
        vecs[3]  = '{8'sd127,  -8'sd1,   -127};
        vecs[4]  = '{8'sd0,    8'sd77,   0};
        vecs[5]  = '{8'sd5,    8'sd1,    5};
        vecs[6]  = '{-8'sd7,   8'sd9,    -63};
        vecs[7]  = '{8'sd2,    8'sd2,    4};
        vecs[8]  = '{-8'sd1,   -8'sd1,   1};
        vecs[9]  = '{8'sd127,  8'sd127,  16129};
        vecs[10] = '{-8'sd5,   8'sd6,    -30};
        vecs[11] = '{8'sd0,    8'sd0,    0};

        #12;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_p", p, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d_busy", i), busy, 1);
            waitDone($sformatf("vec%0d", i), lat);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
            checkOutput($sformatf("vec%0d_lat_le4", i), (lat >= 1 && lat <= 4) ? 1 : 0, 1);
`else
            checkOutput($sformatf("vec%0d_lat", i), lat, 4);
`endif
            checkOutput($sformatf("vec%0d_p", i), longint'($signed(p)), vecs[i].expP);
            tick();
            checkOutput($sformatf("vec%0d_valid_drop", i), out_valid, 0);
            checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1);
        end

        // Backpressure: product held while the consumer stalls
        out_ready = 1'b0;
        applyStimulus(8'hF9, 8'd9);
        waitDone("bp", lat);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bp_hold_valid", out_valid, 1);
            checkOutput("bp_hold_p", longint'($signed(p)), -63);
            checkOutput("bp_hold_in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        checkOutput("bp_release_in_ready_low", in_ready, 0);
        tick();
        checkOutput("bp_release_valid", out_valid, 0);
        checkOutput("bp_release_in_ready", in_ready, 1);

        // Asynchronous reset in the second CALC cycle, away from any clock edge
        applyStimulus(8'd50, 8'hFD);
        tick();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", out_valid, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_p", p, 0);
        checkOutput("arst_in_ready", in_ready, 1);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput("arst_no_valid", out_valid, 0);
        end
        applyStimulus(8'd2, 8'd2);
        waitDone("arst_next", lat);
        checkOutput("arst_next_p", longint'($signed(p)), 4);
        tick();

        // New operands offered while busy must be ignored
        applyStimulus(8'd6, 8'hF9);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = ~in_valid;
            a        = a + 8'd37;
            b        = b + 8'd11;
            tick();
            lat++;
            if (!out_valid) checkOutput("busy_ignore_busy", busy, 1);
        end
        in_valid = 1'b0;
        checkOutput("busy_ignore_done", out_valid, 1);
        checkOutput("busy_ignore_p", longint'($signed(p)), -42);
        tick();
        checkOutput("busy_ignore_idle", in_ready, 1);

        // Zero-skip timing corners; default build always takes four digits
        applyStimulus(8'd0, 8'd77);
        waitDone("zs_a0", lat);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
        checkOutput("zs_a0_lat", lat, 1);
`else
        checkOutput("zs_a0_lat", lat, 4);
`endif
        checkOutput("zs_a0_p", longint'($signed(p)), 0);
        tick();
        applyStimulus(8'd5, 8'd1);
        waitDone("zs_b1", lat);
`ifdef BOOTH_SEQ_ZERO_SKIP_EN
        checkOutput("zs_b1_lat", lat, 2);
`else
        checkOutput("zs_b1_lat", lat, 4);
`endif
        checkOutput("zs_b1_p", longint'($signed(p)), 5);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
